// File: rtl/ps2_keys.sv
//==============================================================================
// Module      : ps2_keys (package)
// Description : Shared constants for the PS/2 keyboard front end: set-2 scan
//               codes, Hack key codes and the receiver state encoding.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package ps2_keys;

    // Prefix bytes
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;

    // Single keys without a prefix
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_ESC   = 8'h76;

    // Letters A..Z in alphabetical order
    localparam logic [7:0] SC_LETTER [26] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
        8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
        8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A
    };

    // Digits 0..9
    localparam logic [7:0] SC_DIGIT [10] = '{
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46
    };

    // Function keys F1..F12
    localparam logic [7:0] SC_FKEY [12] = '{
        8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B,
        8'h83, 8'h0A, 8'h01, 8'h09, 8'h78, 8'h07
    };

    // E0-prefixed navigation keys, ordered to match Hack codes 130..139:
    // Left, Up, Right, Down, Home, End, PgUp, PgDn, Ins, Del
    localparam logic [7:0] SC_NAV [10] = '{
        8'h6B, 8'h75, 8'h74, 8'h72, 8'h6C, 8'h69, 8'h7D, 8'h7A, 8'h70, 8'h71
    };

    // Hack key codes (bases for the contiguous ranges)
    localparam logic [15:0] HK_SPACE = 16'd32;
    localparam logic [15:0] HK_ZERO  = 16'd48;
    localparam logic [15:0] HK_A     = 16'd65;
    localparam logic [15:0] HK_ENTER = 16'd128;
    localparam logic [15:0] HK_BKSP  = 16'd129;
    localparam logic [15:0] HK_LEFT  = 16'd130;
    localparam logic [15:0] HK_ESC   = 16'd140;
    localparam logic [15:0] HK_F1    = 16'd141;

    // Receiver FSM encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

endpackage

`default_nettype wire

// File: rtl/ps2_rx.sv
//==============================================================================
// Module      : ps2_rx
// Description : PS/2 frame receiver: line synchronizers, clock glitch filter,
//               falling-edge strobe, frame FSM with parity/stop checks and
//               inactivity timeout.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ps2_rx
    import ps2_keys::*;
#(
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 2500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT);

    logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic          r_filt_clk;
    logic [FW-1:0] r_filt_cnt;
    logic [1:0]    r_state, w_state_nx;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_parity;
    logic [TW-1:0] r_to_cnt;
    logic          w_strobe, w_timeout, w_frame_ok;

    // Two-stage synchronizers; both lines idle high
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // Glitch filter: the filtered clock follows only after FILTER_LEN agreeing samples
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_filt_clk <= 1'b1;
            r_filt_cnt <= '0;
        end else if (r_clk_s2 == r_filt_clk) begin
            r_filt_cnt <= '0;
        end else if (r_filt_cnt == FILT_LAST) begin
            r_filt_clk <= r_clk_s2;
            r_filt_cnt <= '0;
        end else begin
            r_filt_cnt <= r_filt_cnt + FW'(1);
        end
    end

    // Strobe fires in the cycle the filtered clock is about to go high->low
    assign w_strobe   = r_filt_clk && !r_clk_s2 && (r_filt_cnt == FILT_LAST);
    assign w_timeout  = (r_state != ST_IDLE) && !w_strobe && (r_to_cnt >= TO_LAST);
    assign w_frame_ok = r_dat_s2 && (^{r_shift, r_parity});

    // FSM state register
    always_ff @(posedge clock) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nx;
    end

    // FSM next-state logic; a timeout overrides everything
    always_comb begin
        w_state_nx = r_state;
        if (w_timeout) begin
            w_state_nx = ST_IDLE;
        end else if (w_strobe) begin
            case (r_state)
                ST_IDLE:   if (!r_dat_s2) w_state_nx = ST_DATA;
                ST_DATA:   if (r_bit_cnt == 3'd7) w_state_nx = ST_PARITY;
                ST_PARITY: w_state_nx = ST_STOP;
                ST_STOP:   w_state_nx = ST_IDLE;
                default:   w_state_nx = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: one-cycle byte/error indications as the stop bit resolves
    always_comb begin
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        if (r_state == ST_STOP && w_strobe) begin
            if (w_frame_ok) byte_valid = 1'b1;
            else            frame_err  = 1'b1;
        end else if (w_timeout) begin
            frame_err = 1'b1;
        end
    end

    // Data path: LSB-first shift register, bit counter, parity capture
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_parity  <= 1'b0;
        end else if (w_strobe) begin
            case (r_state)
                ST_IDLE:   r_bit_cnt <= '0;
                ST_DATA: begin
                    r_shift   <= {r_dat_s2, r_shift[7:1]};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                ST_PARITY: r_parity <= r_dat_s2;
                default:   ;
            endcase
        end
    end

    // Inactivity counter: held at 0 in IDLE, cleared by strobes, saturating
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_to_cnt <= '0;
        end else if (r_state == ST_IDLE || w_strobe) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != TO_MAX) begin
            r_to_cnt <= r_to_cnt + TW'(1);
        end
    end

    assign rx_byte = r_shift;

endmodule

`default_nettype wire

// File: rtl/ps2_keyboard.sv
//==============================================================================
// Module      : ps2_keyboard
// Description : PS/2 set-2 keyboard to Hack KBD register bridge. Tracks the
//               E0/F0 prefixes and the held key, and drives the Hack code of
//               the most recently pressed, still-held key.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ps2_keyboard
    import ps2_keys::*;
#(
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 2500
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] key,
    output logic        frame_err
);

    logic        w_rx_valid, w_rx_err;
    logic [7:0]  w_rx_byte;
    logic [8:0]  w_code;
    logic [15:0] w_mapped;
    logic        r_ext, r_brk;
    logic [8:0]  r_held;
    logic [15:0] r_key;
    logic        r_frame_err;

    ps2_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT)
    ) u_rx (
        .clock      (clock),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_valid (w_rx_valid),
        .rx_byte    (w_rx_byte),
        .frame_err  (w_rx_err)
    );

    // {ext, scan} -> Hack code; 0 means the key is not mapped
    function automatic logic [15:0] map_code(input logic [8:0] code);
        logic [15:0] v;
        v = '0;
        if (!code[8]) begin
            for (int i = 0; i < 26; i++)
                if (code[7:0] == SC_LETTER[i]) v = HK_A + 16'(i);
            for (int i = 0; i < 10; i++)
                if (code[7:0] == SC_DIGIT[i]) v = HK_ZERO + 16'(i);
            for (int i = 0; i < 12; i++)
                if (code[7:0] == SC_FKEY[i]) v = HK_F1 + 16'(i);
            if (code[7:0] == SC_SPACE) v = HK_SPACE;
            if (code[7:0] == SC_ENTER) v = HK_ENTER;
            if (code[7:0] == SC_BKSP)  v = HK_BKSP;
            if (code[7:0] == SC_ESC)   v = HK_ESC;
        end else begin
            for (int i = 0; i < 10; i++)
                if (code[7:0] == SC_NAV[i]) v = HK_LEFT + 16'(i);
        end
        return v;
    endfunction

    assign w_code   = {r_ext, w_rx_byte};
    assign w_mapped = map_code(w_code);

    // Prefix tracking, held-key bookkeeping and the key register
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
            r_held      <= '0;
            r_key       <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_rx_err;
            if (w_rx_err) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end else if (w_rx_valid) begin
                if (w_rx_byte == SC_EXT) begin
                    r_ext <= 1'b1;
                end else if (w_rx_byte == SC_BREAK) begin
                    r_brk <= 1'b1;
                end else begin
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                    if (!r_brk) begin
                        if (w_mapped != 16'd0) begin
                            r_key  <= w_mapped;
                            r_held <= w_code;
                        end
                    end else if (w_code == r_held) begin
                        r_key <= '0;
                    end
                end
            end
        end
    end

    assign key       = r_key;
    assign frame_err = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_ps2_keyboard.sv
//==============================================================================
// Module      : tb_ps2_keyboard
// Description : Self-checking bench for ps2_keyboard: directed scenarios plus
//               randomized key traffic against a behavioural keyboard model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ps2_keyboard;

    localparam int FILTER_LEN = 4;
    localparam int TIMEOUT    = 2500;
    localparam int HALF       = 10;

    logic        clock    = 1'b0;
    logic        reset    = 1'b0;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] key;
    logic        frame_err;

    ps2_keyboard #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .key       (key),
        .frame_err (frame_err)
    );

    always #5 clock = ~clock;

    int n_checks   = 0;
    int n_pass     = 0;
    int err_cycles = 0;

    // Count every cycle frame_err is seen high
    always @(negedge clock) if (frame_err === 1'b1) err_cycles++;

    // Reference model state
    bit m_ext, m_brk;
    int m_held, m_key;
    int kmap[int];
    int kcodes[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic add_key(input int code, input int val);
        kmap[code] = val;
        kcodes.push_back(code);
    endtask

    task automatic init_map();
        int letters[26] = '{'h1C,'h32,'h21,'h23,'h24,'h2B,'h34,'h33,'h43,'h3B,'h42,'h4B,'h3A,
                            'h31,'h44,'h4D,'h15,'h2D,'h1B,'h2C,'h3C,'h2A,'h1D,'h22,'h35,'h1A};
        int digits[10]  = '{'h45,'h16,'h1E,'h26,'h25,'h2E,'h36,'h3D,'h3E,'h46};
        int fkeys[12]   = '{'h05,'h06,'h04,'h0C,'h03,'h0B,'h83,'h0A,'h01,'h09,'h78,'h07};
        int nav[10]     = '{'h6B,'h75,'h74,'h72,'h6C,'h69,'h7D,'h7A,'h70,'h71};
        for (int i = 0; i < 26; i++) add_key(letters[i], 65 + i);
        for (int i = 0; i < 10; i++) add_key(digits[i], 48 + i);
        for (int i = 0; i < 12; i++) add_key(fkeys[i], 141 + i);
        for (int i = 0; i < 10; i++) add_key(256 + nav[i], 130 + i);
        add_key('h29, 32);
        add_key('h5A, 128);
        add_key('h66, 129);
        add_key('h76, 140);
    endtask

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_held = 0; m_key = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int c;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            c = (m_ext ? 256 : 0) + int'(b);
            if (!m_brk) begin
                if (kmap.exists(c)) begin
                    m_key  = kmap[c];
                    m_held = c;
                end
            end else if (c == m_held) begin
                m_key = 0;
            end
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    // Drive the first nbits bits of an 11-bit frame, then idle the bus
    task automatic send_bits(input logic [7:0] b, input bit flip_par, input bit bad_stop, input int nbits);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ flip_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            wait_clks(HALF);
            ps2_clk = 1'b0;
            wait_clks(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        wait_clks(HALF);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int e0;
        e0 = err_cycles;
        send_bits(b, 1'b0, 1'b0, 11);
        model_byte(b);
        check($sformatf("key_after_%02h", b), key, m_key);
        check($sformatf("noerr_after_%02h", b), err_cycles - e0, 0);
    endtask

    task automatic send_bad(input logic [7:0] b, input bit flip_par, input bit bad_stop);
        int e0;
        e0 = err_cycles;
        send_bits(b, flip_par, bad_stop, 11);
        m_ext = 0;
        m_brk = 0;
        check($sformatf("key_after_bad_%02h", b), key, m_key);
        check($sformatf("err_pulse_bad_%02h", b), err_cycles - e0, 1);
    endtask

    task automatic press(input int code);
        if (code >= 256) send_byte(8'hE0);
        send_byte(code[7:0]);
    endtask

    task automatic release_key(input int code);
        if (code >= 256) send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(code[7:0]);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int e0, r, c;
        init_map();
        model_reset();

        // Reset state
        reset = 1'b0;
        wait_clks(5);
        check("rst_key", key, 0);
        check("rst_err", frame_err, 0);
        reset = 1'b1;
        wait_clks(5);

        // Press / release A
        press('h1C);
        check("A_pressed", key, 65);
        release_key('h1C);
        check("A_released", key, 0);

        // Extended Up arrow
        press(256 + 'h75);
        check("up_pressed", key, 131);
        release_key(256 + 'h75);
        check("up_released", key, 0);

        // Overlapping A and B
        press('h1C);
        press('h32);
        check("B_over_A", key, 66);
        release_key('h1C);
        check("B_after_relA", key, 66);
        release_key('h32);
        check("B_released", key, 0);

        // Parity error, then a good Space
        send_bad(8'h1C, 1'b1, 1'b0);
        check("par_err_key", key, 0);
        press('h29);
        check("space", key, 32);

        // Stop-bit error leaves key alone
        send_bad(8'h1C, 1'b0, 1'b1);
        check("stop_err_key", key, 32);

        // Timeout after 4 bits of a frame
        e0 = err_cycles;
        send_bits(8'h1C, 1'b0, 1'b0, 4);
        wait_clks(TIMEOUT - 100);
        check("to_not_early", err_cycles - e0, 0);
        wait_clks(200);
        check("to_pulse", err_cycles - e0, 1);
        check("to_key", key, 32);
        m_ext = 0;
        m_brk = 0;
        press('h76);
        check("esc_after_to", key, 140);

        // Reset mid-frame
        e0 = err_cycles;
        send_bits(8'h5A, 1'b0, 1'b0, 5);
        reset = 1'b0;
        wait_clks(3);
        reset = 1'b1;
        wait_clks(2);
        model_reset();
        check("midrst_key", key, 0);
        check("midrst_noerr", err_cycles - e0, 0);
        press('h5A);
        check("enter_after_rst", key, 128);

        // Randomized traffic
        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 9);
            if (r <= 4) begin
                press(kcodes[$urandom_range(0, kcodes.size() - 1)]);
            end else if (r <= 7) begin
                if (m_held != 0 && $urandom_range(0, 1) == 1) c = m_held;
                else c = kcodes[$urandom_range(0, kcodes.size() - 1)];
                release_key(c);
            end else if (r == 8) begin
                send_byte(8'($urandom_range(0, 255)));
            end else begin
                if ($urandom_range(0, 1) == 1) send_bad(8'($urandom_range(0, 255)), 1'b1, 1'b0);
                else send_bad(8'($urandom_range(0, 255)), 1'b0, 1'b1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
